// File: rtl/extend_pkg.sv
// extend_pkg: shared widths, output-register states and extension modes for extend_arbiter
package extend_pkg;
  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 8;
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;
endpackage

// File: rtl/ext_unit.sv
// ext_unit: combinational IN_W-to-OUT_W zero/sign extender
module ext_unit
  import extend_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  d,
  input  logic             sext,
  output logic [OUT_W-1:0] q
);
  logic w_fill;
  // upper bits copy the MSB only in sign mode
  always_comb begin
    w_fill = (sext == EXT_SIGN) ? d[IN_W-1] : 1'b0;
    q = {{(OUT_W-IN_W){w_fill}}, d};
  end
endmodule

// File: rtl/extend_arbiter.sv
// extend_arbiter: round-robin arbiter sharing one extension unit, with a single-entry output register
module extend_arbiter
  import extend_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]      req_sext,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
);
  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [OUT_W-1:0]  r_data;
  logic [ID_W-1:0]   r_id;
  logic              w_any;
  logic              w_grant;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_ptr_next;
  logic [IN_W-1:0]   w_d;
  logic              w_sext;
  logic [OUT_W-1:0]  w_ext;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_id    = r_id;
  // scan downward from the farthest candidate so the one nearest r_ptr is written last and wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  // grant only when the output slot is free or draining; never while in reset
  always_comb begin
    w_grant    = !rst && w_any && (!out_valid || out_ready);
    req_ready  = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
    w_d        = req_data[w_win*IN_W +: IN_W];
    w_sext     = req_sext[w_win];
  end
  ext_unit #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_ext (
    .d   (w_d),
    .sext(w_sext),
    .q   (w_ext)
  );
  // output register loads on a grant, drains on accept, and advances the pointer past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_grant) begin
      r_state <= ST_FULL;
      r_ptr   <= w_ptr_next;
      r_data  <= w_ext;
      r_id    <= w_win;
    end else if (out_ready) begin
      r_state <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_extend_arbiter.sv
// tb_extend_arbiter: directed self-checking bench for extend_arbiter with NUM_REQ=2
module tb_extend_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [1:0] req_sext;
  logic [1:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [0:0] out_id;
  logic       out_ready;
  int total;
  int bad;
  extend_arbiter #(
    .NUM_REQ(2),
    .IN_W   (4),
    .OUT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_sext (req_sext),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [3:0] c, input logic m);
    return (m && c >= 4'd8) ? 8'({4'd0, c}) + 8'hF0 : 8'({4'd0, c});
  endfunction
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = 2'b11;
    req_data = 8'h00;
    req_sext = 2'b00;
    out_ready = 1'b0;
    #1;
    chk("rdy_in_rst", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    rst = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_data", 32'(out_data), 32'h0);
      chk("idle_rdy", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    req_valid = 2'b01;
    req_data = 8'h0A;
    req_sext = 2'b00;
    #1;
    chk("ext_rdy0", 32'(req_ready), 32'h1);
    tick();
    chk("zext_valid", 32'(out_valid), 32'h1);
    chk("zext_data", 32'(out_data), 32'h0A);
    chk("zext_id", 32'(out_id), 32'h0);
    req_sext = 2'b01;
    #1;
    chk("ext_rdy1", 32'(req_ready), 32'h1);
    tick();
    chk("sext_neg", 32'(out_data), 32'hFA);
    chk("sext_neg_id", 32'(out_id), 32'h0);
    req_data = 8'h07;
    tick();
    chk("sext_pos", 32'(out_data), 32'h07);
    req_valid = 2'b00;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_hold", 32'(out_data), 32'h07);
    req_valid = 2'b11;
    req_data = 8'h21;
    req_sext = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_id", 32'(out_id), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_data", 32'(out_data), (k % 2 == 0) ? 32'h02 : 32'h01);
    end
    req_valid = 2'b00;
    tick();
    chk("rr_drain", 32'(out_valid), 32'h0);
    req_valid = 2'b10;
    req_data = 8'h59;
    req_sext = 2'b01;
    out_ready = 1'b0;
    tick();
    chk("bp_load", 32'(out_data), 32'h05);
    chk("bp_load_id", 32'(out_id), 32'h1);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rdy", 32'(req_ready), 32'h0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_hold", 32'(out_data), 32'h05);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(req_ready), 32'h1);
    tick();
    chk("bp_next_data", 32'(out_data), 32'hF9);
    chk("bp_next_id", 32'(out_id), 32'h0);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_id", 32'(out_id), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("mid_rst_ptr", 32'(req_ready), 32'h1);
    tick();
    chk("mid_rst_grant", 32'(out_id), 32'h0);
    chk("mid_rst_gdata", 32'(out_data), 32'hF9);
    req_valid = 2'b10;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        req_data = {4'(c), 4'h0};
        req_sext = {m[0], 1'b0};
        #1;
        chk("sweep_rdy", 32'(req_ready), 32'h2);
        tick();
        chk("sweep_data", 32'(out_data), 32'(model(4'(c), m[0])));
        chk("sweep_id", 32'(out_id), 32'h1);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/extend_arbiter.md
# extend_arbiter

Round-robin arbiter and sequencer that shares one 4-to-8-bit extension unit between several requesters. Each requester presents a 4-bit value and a sign/zero mode over a valid/ready handshake. The block grants one requester per cycle, extends its value, and holds the 8-bit result plus the requester ID in a single-entry output register until downstream accepts it. It sits between the nibble-producing front-end units and the byte-wide datapath.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2–8.
- `IN_W`, default 4: input value width.
- `OUT_W`, default 8: output width; must be greater than `IN_W`.
- `ID_W` (localparam) = `$clog2(NUM_REQ)`: width of the requester ID.

Ports (all signals are synchronous to `clk`; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*IN_W  requester i occupies bits `[i*IN_W +: IN_W]`.
- `req_sext`  in  NUM_REQ  per-requester mode: 1 = sign-extend, 0 = zero-extend.
- `req_ready`  out  NUM_REQ  one-hot grant; combinational from state and `req_valid`.
- `out_valid`  out  1  output register holds a result.
- `out_data`  out  OUT_W  extended result.
- `out_id`  out  ID_W  index of the requester that produced `out_data`.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- The output register has two states, with `out_valid` equal to the state being FULL.
  - EMPTY → FULL: on a grant.
  - FULL → FULL: on a grant in the same cycle as `out_ready`.
  - FULL → EMPTY: on `out_ready` with no grant.
- `can_accept = !out_valid || out_ready`.
  - A grant happens only when `can_accept` is high and at least one `req_valid` is high.
- Arbitration is round-robin.
  - The search starts at pointer `rr_ptr` and proceeds upward with wrap-around.
  - The first requester with `req_valid` high wins.
- After a grant to requester g, `rr_ptr` becomes `(g+1) mod NUM_REQ`. Without a grant, `rr_ptr` holds.
- `req_ready[g]` is high only for the winner, and only when `can_accept` is high. All other bits are 0.
- A transfer on requester i occurs when `req_valid[i] && req_ready[i]`.
- Extension, with `d = req_data` of the winner:
  - Zero mode: `out_data = {(OUT_W-IN_W)'b0, d}`.
  - Sign mode: upper bits replicate `d[IN_W-1]`.
- `out_data` and `out_id` change only on a grant. They hold their value while FULL and not accepted.
- Requester inputs need not be stable while that requester is not granted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_id`=0, `rr_ptr`=0, state EMPTY. `req_ready` is 0 while `rst` is high.
- Latency: a grant in cycle N gives `out_valid`=1 with the result in cycle N+1.
- Throughput: one result per cycle while `out_ready` is held high.
- Backpressure: while FULL with `out_ready` low, all `req_ready` are 0 and the output holds.
- Simultaneous accept and grant: the old result leaves and the new one loads on the same edge, with no bubble.
- Wrap-around: the pointer at `NUM_REQ-1` with a grant goes to 0.
- Reset mid-operation: a pending result is discarded and the next cycle is EMPTY with `rr_ptr`=0. A handshake in the reset cycle is not a transfer.
- No requester valid: no state change except draining the output.

## Structure
- Package `extend_pkg`:
  - Defaults for `IN_W` and `OUT_W`.
  - The state typedef (`ST_EMPTY`, `ST_FULL`).
  - The mode constants `EXT_ZERO`=0 and `EXT_SIGN`=1.
- Sub-module `ext_unit`: a combinational IN_W→OUT_W extender with an `sext` input.
  - Instantiated once after the grant mux.
  - Can be checked standalone against all 16 input codes in both modes.
- Arbiter logic, grant mux and output register live in `extend_arbiter` itself.

## Test plan
- Reset, then idle: after `rst` falls, `out_valid`=0, `out_data`=0x00 and `req_ready`=0 for 10 cycles with no valid.
- Extension: requester 0 with `data`=0xA and `sext`=0 → `out_data`=0x0A, `out_id`=0 one cycle later. With `sext`=1 → 0xFA. `data`=0x7 with `sext`=1 → 0x07.
- Round-robin fairness: both requesters valid continuously with `out_ready`=1 → grants alternate 0,1,0,1, `out_id` alternates each cycle, with no bubble.
- Backpressure: `out_ready`=0 with a result 0x05 held and both requesters valid for 5 cycles → `out_data` stays 0x05 and all `req_ready`=0. Raising `out_ready` gives a grant the same cycle.
- Reset mid-operation: assert `rst` while FULL with `out_ready`=0 → next cycle `out_valid`=0 and `rr_ptr`=0, and the first grant goes to requester 0.
- Exhaustive: sweep all 16 codes × 2 modes through requester `NUM_REQ-1` → every result matches the reference model and `out_id`=`NUM_REQ-1`.
